// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matrix packer.
// Element width and maximum matrix dimension live here.
package matmul_pkg;

  localparam int BUS_WIDTH_DEF = 16;
  localparam int MAX_DIM_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_idx_counter.sv
// Row-major (row, col) walker over a rows x cols window.
// Column wraps to zero at cols and bumps the row.
module matrix_idx_counter #(
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = $clog2(MAX_DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last
);

  assign last = (row == rows) && (col == cols);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == cols) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_packer.sv
// Collects a row-major element stream into a registered matrix
// and holds it until the consumer acknowledges.
module matrix_packer
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int MAX_DIM   = MAX_DIM_DEF,
  parameter int DIM_W     = $clog2(MAX_DIM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [DIM_W-1:0]                   rows_i,
  input  logic [DIM_W-1:0]                   cols_i,
  input  logic                               elem_valid_i,
  input  logic [BUS_WIDTH-1:0]               elem_data_i,
  output logic                               elem_ready_o,
  output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] matrix_o,
  output logic                               done_o,
  input  logic                               ack_i,
  output logic                               busy_o,
  output logic                               err_o
);

  state_t               state;
  logic [DIM_W-1:0]     rows_q;
  logic [DIM_W-1:0]     cols_q;
  logic [DIM_W-1:0]     row;
  logic [DIM_W-1:0]     col;
  logic                 last;
  logic                 hs;
  logic                 accept;
  logic [BUS_WIDTH-1:0] mem [MAX_DIM][MAX_DIM];

  assign elem_ready_o = (state == FILL);
  assign busy_o       = (state != IDLE);
  assign hs           = elem_valid_i && elem_ready_o;
  assign accept       = start_i &&
                        ((state == IDLE) ||
                         ((state == DONE) && ack_i));

  matrix_idx_counter #(
    .MAX_DIM (MAX_DIM),
    .DIM_W   (DIM_W)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (hs),
    .rows    (rows_q),
    .cols    (cols_q),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
      assign matrix_o[((i*MAX_DIM)+j)*BUS_WIDTH +: BUS_WIDTH] = mem[i][j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++)
          mem[i][j] <= '0;
    end else begin
      err_o <= start_i &&
               ((state == FILL) ||
                ((state == DONE) && !ack_i));
      unique case (state)
        IDLE: ;
        FILL: begin
          if (hs) begin
            mem[row][col] <= elem_data_i;
            if (last) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ack_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // accept only fires in IDLE or DONE, so it never races a write
      if (accept) begin
        state  <= FILL;
        rows_q <= rows_i;
        cols_q <= cols_i;
        done_o <= 1'b0;
        for (int i = 0; i < MAX_DIM; i++)
          for (int j = 0; j < MAX_DIM; j++)
            mem[i][j] <= '0;
      end
    end
  end

endmodule
